// File: rtl/fractal_sync_1d_rf_arb.sv
// fractal_sync_1d_rf_arb: per-port round-robin arbiter and check sequencer for the 1D sync RF.
// Optional issue-stall counter enabled by defining FRACTAL_SYNC_RF_ARB_STALL_CNT_EN.
module fractal_sync_1d_rf_arb #(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned LEVEL_WIDTH = 1,
    parameter int unsigned ID_WIDTH    = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [N_REQ-1:0]             req_valid_i,
    output logic [N_REQ-1:0]             req_ready_o,
    input  logic [N_REQ*LEVEL_WIDTH-1:0] req_level_i,
    input  logic [N_REQ*ID_WIDTH-1:0]    req_id_i,
    input  logic [N_REQ-1:0]             req_remote_i,
    output logic [N_REQ-1:0]             rsp_valid_o,
    input  logic [N_REQ-1:0]             rsp_ready_i,
    output logic [N_REQ*2-1:0]           rsp_status_o,
    output logic [2*LEVEL_WIDTH-1:0]     rf_level_o,
    output logic [2*ID_WIDTH-1:0]        rf_id_o,
    output logic [1:0]                   rf_check_local_o,
    output logic [1:0]                   rf_check_remote_o,
    input  logic [1:0]                   rf_present_local_i,
    input  logic [1:0]                   rf_present_remote_i,
    input  logic [1:0]                   rf_id_err_i,
    input  logic [1:0]                   rf_sig_err_i,
    input  logic                         rf_bypass_local_i,
    input  logic                         rf_bypass_remote_i,
    output logic [15:0]                  stall_cnt_o
);

    localparam int unsigned N_GRP = N_REQ / 2;
    localparam int unsigned GW    = (N_GRP > 1) ? $clog2(N_GRP) : 1;

    localparam logic [1:0] ST_STORED  = 2'd0;
    localparam logic [1:0] ST_PRESENT = 2'd1;
    localparam logic [1:0] ST_ID_ERR  = 2'd2;
    localparam logic [1:0] ST_SIG_ERR = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    logic [1:0] issue_stall;

    for (genvar p = 0; p < 2; p++) begin : g_port
        state_e                 state_q;
        logic [GW-1:0]          rr_q;
        logic [GW-1:0]          owner_q;
        logic [LEVEL_WIDTH-1:0] level_q;
        logic [ID_WIDTH-1:0]    id_q;
        logic                   remote_q;
        logic [1:0]             status_q;

        logic                   found;
        logic [GW-1:0]          win;
        logic [GW-1:0]          win_next;
        logic [LEVEL_WIDTH-1:0] sel_level;
        logic [ID_WIDTH-1:0]    sel_id;
        logic                   sel_remote;
        logic                   rsp_ack;
        logic                   bypass;
        logic                   issue_go;
        logic [1:0]             status_d;

        // First valid requester at or after the RR pointer, wrapping in the group
        always_comb begin
            found = 1'b0;
            win   = '0;
            for (int unsigned j = 0; j < N_GRP; j++) begin
                if (!found && GW'(j) >= rr_q && req_valid_i[2*j+p]) begin
                    found = 1'b1;
                    win   = GW'(j);
                end
            end
            for (int unsigned j = 0; j < N_GRP; j++) begin
                if (!found && req_valid_i[2*j+p]) begin
                    found = 1'b1;
                    win   = GW'(j);
                end
            end
        end

        // Mux the winner's request fields and the owner's response ready
        always_comb begin
            sel_level  = '0;
            sel_id     = '0;
            sel_remote = 1'b0;
            rsp_ack    = 1'b0;
            for (int unsigned j = 0; j < N_GRP; j++) begin
                if (GW'(j) == win) begin
                    sel_level  = req_level_i[(2*j+p)*LEVEL_WIDTH +: LEVEL_WIDTH];
                    sel_id     = req_id_i[(2*j+p)*ID_WIDTH +: ID_WIDTH];
                    sel_remote = req_remote_i[2*j+p];
                end
                if (GW'(j) == owner_q) begin
                    rsp_ack = rsp_ready_i[2*j+p];
                end
            end
        end

        assign win_next = (win == GW'(N_GRP - 1)) ? '0 : win + GW'(1);

        assign bypass   = remote_q ? rf_bypass_remote_i : rf_bypass_local_i;
        assign issue_go = (state_q == ISSUE) && !bypass;
        assign issue_stall[p] = (state_q == ISSUE) && bypass;

        // Encode the RF result; errors win over present
        always_comb begin
            status_d = ST_STORED;
            if (remote_q) begin
                if (rf_sig_err_i[p]) begin
                    status_d = ST_SIG_ERR;
                end else if (rf_present_remote_i[p]) begin
                    status_d = ST_PRESENT;
                end
            end else begin
                if (rf_id_err_i[p]) begin
                    status_d = ST_ID_ERR;
                end else if (rf_present_local_i[p]) begin
                    status_d = ST_PRESENT;
                end
            end
        end

        // Port FSM: grant, issue one check, hold the response until taken
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                state_q  <= IDLE;
                rr_q     <= '0;
                owner_q  <= '0;
                level_q  <= '0;
                id_q     <= '0;
                remote_q <= 1'b0;
                status_q <= ST_STORED;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (found) begin
                            owner_q  <= win;
                            rr_q     <= win_next;
                            level_q  <= sel_level;
                            id_q     <= sel_id;
                            remote_q <= sel_remote;
                            state_q  <= ISSUE;
                        end
                    end
                    ISSUE: begin
                        if (!bypass) begin
                            status_q <= status_d;
                            state_q  <= RESP;
                        end
                    end
                    RESP: begin
                        if (rsp_ack) begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end

        assign rf_check_local_o[p]  = issue_go && !remote_q;
        assign rf_check_remote_o[p] = issue_go && remote_q;
        assign rf_level_o[p*LEVEL_WIDTH +: LEVEL_WIDTH] = level_q;
        assign rf_id_o[p*ID_WIDTH +: ID_WIDTH]          = id_q;

        for (genvar j = 0; j < N_GRP; j++) begin : g_req
            localparam int unsigned I = 2 * j + p;
            logic hit_rsp;
            assign req_ready_o[I] = (state_q == IDLE) && found
                                    && (win == GW'(j));
            assign hit_rsp = (state_q == RESP) && (owner_q == GW'(j));
            assign rsp_valid_o[I] = hit_rsp;
            assign rsp_status_o[2*I +: 2] = hit_rsp ? status_q : 2'b00;
        end
    end

`ifdef FRACTAL_SYNC_RF_ARB_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of cycles with any port stalled in ISSUE
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if (|issue_stall && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`else
    logic unused_stall;
    assign unused_stall = ^issue_stall;
    assign stall_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_fractal_sync_1d_rf_arb.sv
// tb_fractal_sync_1d_rf_arb: scoreboard bench for the 1D RF arbiter.
// Expected statuses are queued per requester at drive time and popped on response handshakes.
module tb_fractal_sync_1d_rf_arb;

    localparam int N  = 4;
    localparam int LW = 1;
    localparam int IW = 1;

    localparam logic [1:0] STORED  = 2'd0;
    localparam logic [1:0] PRESENT = 2'd1;
    localparam logic [1:0] ID_ERR  = 2'd2;
    localparam logic [1:0] SIG_ERR = 2'd3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid_i = '0;
    logic [N-1:0]    req_ready_o;
    logic [N*LW-1:0] req_level_i = '0;
    logic [N*IW-1:0] req_id_i = '0;
    logic [N-1:0]    req_remote_i = '0;
    logic [N-1:0]    rsp_valid_o;
    logic [N-1:0]    rsp_ready_i = '0;
    logic [N*2-1:0]  rsp_status_o;
    logic [2*LW-1:0] rf_level_o;
    logic [2*IW-1:0] rf_id_o;
    logic [1:0]      rf_check_local_o;
    logic [1:0]      rf_check_remote_o;
    logic [1:0]      rf_present_local_i = '0;
    logic [1:0]      rf_present_remote_i = '0;
    logic [1:0]      rf_id_err_i = '0;
    logic [1:0]      rf_sig_err_i = '0;
    logic            rf_bypass_local_i = 1'b0;
    logic            rf_bypass_remote_i = 1'b0;
    logic [15:0]     stall_cnt_o;

    int n_chk  = 0;
    int n_fail = 0;

    logic [1:0] exp_q [N][$];

    fractal_sync_1d_rf_arb #(
        .N_REQ(N), .LEVEL_WIDTH(LW), .ID_WIDTH(IW)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_level_i(req_level_i),
        .req_id_i(req_id_i),
        .req_remote_i(req_remote_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_status_o(rsp_status_o),
        .rf_level_o(rf_level_o),
        .rf_id_o(rf_id_o),
        .rf_check_local_o(rf_check_local_o),
        .rf_check_remote_o(rf_check_remote_o),
        .rf_present_local_i(rf_present_local_i),
        .rf_present_remote_i(rf_present_remote_i),
        .rf_id_err_i(rf_id_err_i),
        .rf_sig_err_i(rf_sig_err_i),
        .rf_bypass_local_i(rf_bypass_local_i),
        .rf_bypass_remote_i(rf_bypass_remote_i),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pop and compare on every response handshake
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                if (rsp_valid_o[i] && rsp_ready_i[i]) begin
                    if (exp_q[i].size() == 0)
                        chk($sformatf("rsp%0d_unexpected", i), 1, 0);
                    else
                        chk($sformatf("rsp%0d_status", i),
                            rsp_status_o[2*i +: 2], exp_q[i].pop_front());
                end
            end
        end
    end

    task automatic set_req(input int i, input logic lvl, input logic id,
                           input logic rem);
        req_valid_i[i]  = 1'b1;
        req_level_i[i]  = lvl;
        req_id_i[i]     = id;
        req_remote_i[i] = rem;
    endtask

    task automatic wait_grant(input logic [N-1:0] mask);
        int  k  = 0;
        bit  ok = 0;
        while (k < 20 && !ok) begin
            @(negedge clk);
            if ((req_ready_o & mask) == mask) ok = 1;
            else begin
                @(posedge clk); #1;
                k++;
            end
        end
        chk("grant", req_ready_o & mask, mask);
        @(posedge clk); #1;
        req_valid_i = req_valid_i & ~mask;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid_i = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    int   order[$];
    int   gcyc[$];
    logic [15:0] sc0;
    int   exp_sc;

    initial begin
`ifdef FRACTAL_SYNC_RF_ARB_STALL_CNT_EN
        exp_sc = 5;
`else
        exp_sc = 0;
`endif
        do_reset();
        rsp_ready_i = '1;

        @(negedge clk);
        chk("rst_ready", req_ready_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_status", rsp_status_o, 0);
        chk("rst_check", {rf_check_local_o, rf_check_remote_o}, 0);
        chk("rst_level_id", {rf_level_o, rf_id_o}, 0);
        chk("rst_stall_cnt", stall_cnt_o, 0);
        @(posedge clk); #1;

        // Single local request, STORED then PRESENT
        rf_present_local_i = 2'b00;
        set_req(0, 1'b0, 1'b1, 1'b0);
        exp_q[0].push_back(STORED);
        wait_grant(4'b0001);
        @(negedge clk);
        chk("t1_check_local", rf_check_local_o, 2'b01);
        chk("t1_check_remote", rf_check_remote_o, 2'b00);
        chk("t1_rf_id", rf_id_o[0], 1);
        @(negedge clk);
        chk("t1_rsp_valid", rsp_valid_o, 4'b0001);
        @(posedge clk); #1;
        rf_present_local_i = 2'b01;
        set_req(0, 1'b0, 1'b1, 1'b0);
        exp_q[0].push_back(PRESENT);
        wait_grant(4'b0001);
        repeat (4) @(posedge clk);
        #1;

        // Round robin on port 0 from a fresh pointer
        do_reset();
        rf_present_local_i = 2'b00;
        set_req(0, 1'b0, 1'b0, 1'b0);
        set_req(2, 1'b1, 1'b1, 1'b0);
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            chk("rr_port1_quiet",
                {rf_check_local_o[1], rf_check_remote_o[1]}, 0);
            if (req_ready_o[0]) begin
                order.push_back(0);
                gcyc.push_back(c);
                exp_q[0].push_back(STORED);
            end
            if (req_ready_o[2]) begin
                order.push_back(2);
                gcyc.push_back(c);
                exp_q[2].push_back(STORED);
            end
            @(posedge clk); #1;
        end
        req_valid_i = '0;
        chk("rr_count", order.size() >= 4, 1);
        if (order.size() >= 4) begin
            chk("rr_g0", order[0], 0);
            chk("rr_g1", order[1], 2);
            chk("rr_g2", order[2], 0);
            chk("rr_g3", order[3], 2);
            chk("rr_period", gcyc[1] - gcyc[0], 3);
        end
        repeat (4) @(posedge clk);
        #1;

        // Both ports in parallel
        rf_present_local_i  = 2'b01;
        rf_present_remote_i = 2'b00;
        set_req(0, 1'b0, 1'b0, 1'b0);
        set_req(1, 1'b1, 1'b0, 1'b1);
        exp_q[0].push_back(PRESENT);
        exp_q[1].push_back(STORED);
        wait_grant(4'b0011);
        @(negedge clk);
        chk("par_check_local", rf_check_local_o, 2'b01);
        chk("par_check_remote", rf_check_remote_o, 2'b10);
        @(negedge clk);
        chk("par_rsp_valid", rsp_valid_o, 4'b0011);
        @(posedge clk); #1;

        // Error beats present
        rf_sig_err_i        = 2'b10;
        rf_present_remote_i = 2'b10;
        rf_id_err_i         = 2'b01;
        rf_present_local_i  = 2'b01;
        set_req(1, 1'b0, 1'b1, 1'b1);
        set_req(0, 1'b1, 1'b1, 1'b0);
        exp_q[1].push_back(SIG_ERR);
        exp_q[0].push_back(ID_ERR);
        wait_grant(4'b0011);
        repeat (3) @(posedge clk);
        #1;
        rf_sig_err_i        = '0;
        rf_present_remote_i = '0;
        rf_id_err_i         = '0;
        rf_present_local_i  = '0;

        // Remote bypass stall for five cycles
        rf_bypass_remote_i = 1'b1;
        sc0 = stall_cnt_o;
        set_req(3, 1'b1, 1'b1, 1'b1);
        exp_q[3].push_back(STORED);
        wait_grant(4'b1000);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("stall_no_check", rf_check_remote_o, 2'b00);
            @(posedge clk); #1;
        end
        rf_bypass_remote_i = 1'b0;
        @(negedge clk);
        chk("stall_release_check", rf_check_remote_o, 2'b10);
        chk("stall_rf_level", rf_level_o[1], 1);
        chk("stall_cnt", stall_cnt_o - sc0, exp_sc);
        repeat (3) @(posedge clk);
        #1;

        // Reset while a response is pending
        rsp_ready_i[0] = 1'b0;
        set_req(0, 1'b1, 1'b0, 1'b0);
        wait_grant(4'b0001);
        @(negedge clk);
        @(negedge clk);
        chk("mid_rsp_pending", rsp_valid_o[0], 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        chk("mid_rst_rsp_valid", rsp_valid_o, 0);
        chk("mid_rst_status", rsp_status_o, 0);
        chk("mid_rst_level", rf_level_o, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rsp_ready_i = '1;
        set_req(0, 1'b0, 1'b0, 1'b0);
        set_req(2, 1'b0, 1'b0, 1'b0);
        exp_q[0].push_back(STORED);
        exp_q[2].push_back(STORED);
        @(negedge clk);
        chk("post_rst_rr", req_ready_o, 4'b0001);
        @(posedge clk); #1;
        req_valid_i[0] = 1'b0;
        wait_grant(4'b0100);

        repeat (8) @(posedge clk);
        for (int i = 0; i < N; i++)
            chk($sformatf("drain%0d", i), exp_q[i].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fractal_sync_1d_rf_arb.md
Name: fractal_sync_1d_rf_arb

Overview:
- Arbiter and sequencer in front of the 1D fractal-sync register file.
- Shares the RF's two check ports among N_REQ requesters; requester i is statically bound to RF port i%2.
- Per port: round-robin grant, one check pulse issued to the RF, result captured, response returned to the winner over a valid/ready handshake.
- Sits between the network-side sync request interfaces and the 1D RF instance.

Parameters:
- N_REQ, 4, number of requesters; must be even and >=2; N_REQ/2 requesters per port.
- LEVEL_WIDTH, 1, width of the level field.
- ID_WIDTH, 1, width of the barrier ID field.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  N_REQ  request valid per requester
- req_ready_o  out  N_REQ  request accepted, one-cycle pulse
- req_level_i  in  N_REQ*LEVEL_WIDTH  level; requester i occupies slice i
- req_id_i  in  N_REQ*ID_WIDTH  barrier ID per requester
- req_remote_i  in  N_REQ  1=remote RF check, 0=local RF check
- rsp_valid_o  out  N_REQ  response valid per requester
- rsp_ready_i  in  N_REQ  response consumed
- rsp_status_o  out  N_REQ*2  0=STORED, 1=PRESENT, 2=ID_ERR, 3=SIG_ERR
- rf_level_o  out  2*LEVEL_WIDTH  level to RF port p
- rf_id_o  out  2*ID_WIDTH  ID to RF port p
- rf_check_local_o  out  2  local check pulse per port
- rf_check_remote_o  out  2  remote check pulse per port
- rf_present_local_i  in  2  RF local present
- rf_present_remote_i  in  2  RF remote present
- rf_id_err_i  in  2  RF local ID error
- rf_sig_err_i  in  2  RF remote signal error
- rf_bypass_local_i  in  1  local RF unavailable; stalls local issue
- rf_bypass_remote_i  in  1  remote RF unavailable; stalls remote issue
- stall_cnt_o  out  16  issue-stall cycle count (see Optional Feature)

Behaviour:
- Reset: all outputs 0, both port FSMs IDLE, RR pointers 0, latched fields 0, stall counter 0.
- Two independent, identical port FSMs p∈{0,1}, each serving requesters {i : i%2==p}.
- IDLE:
  - If any valid requester in the group: pick the first valid at or after rr_ptr[p], cyclic within the group.
  - Pulse req_ready_o for the winner; latch level, ID, remote flag and owner index; rr_ptr[p] <= winner's group index + 1, mod N_REQ/2; go to ISSUE.
  - No grant while rsp_valid_o of that port's owner is pending; this cannot occur in IDLE.
- ISSUE:
  - Stall if the latched type's bypass input is high (remote flag selects rf_bypass_remote_i, otherwise rf_bypass_local_i). While stalled: no check asserted, remain in ISSUE.
  - Otherwise assert exactly one of rf_check_local_o[p] or rf_check_remote_o[p] for one cycle, with rf_level_o/rf_id_o driven from the latch.
  - RF result is combinational in the same cycle; capture it at that clock edge and go to RESP.
  - rf_level_o/rf_id_o hold latched values in all states; 0 after reset until the first grant.
- Status encoding:
  - Local: id_err → ID_ERR; else present → PRESENT; else STORED.
  - Remote: sig_err → SIG_ERR; else present → PRESENT; else STORED.
  - Error has priority over present.
- RESP:
  - rsp_valid_o[owner]=1 with stable rsp_status_o until rsp_ready_i[owner]; on the handshake go to IDLE.
  - Back-to-back: next grant no earlier than the cycle after the response handshake, so minimum request-to-request period per port is 3 cycles.
- Latency: accept→check 1 cycle; check→rsp_valid 1 cycle.
- Simultaneous events:
  - Both ports may issue in the same cycle; a shared bypass stalls both ports if both need that type.
  - A requester deasserting valid before ready is permitted; it is simply not granted.
- Reset mid-operation: returns everything to reset state immediately; in-flight requests are dropped with no response.
- Unused rsp_status_o slices read 0 when rsp_valid_o is low.

Optional Feature:
- Macro: FRACTAL_SYNC_RF_ARB_STALL_CNT_EN.
- Defined: stall_cnt_o increments by 1 each cycle in which at least one port is in ISSUE and stalled; it saturates at 0xFFFF and is cleared only by reset.
- Undefined: stall_cnt_o is tied to 0 and no counter is instantiated.

Test Plan:
- Single local request: req0 id=1 level=0, RF present_local=0 → req_ready_o[0] at cycle 1, rf_check_local_o[0] at cycle 2, rsp_valid_o[0] at cycle 3 with status STORED; a second req0 with present=1 → PRESENT.
- Round-robin on port 0, N_REQ=4: req0 and req2 held valid continuously with immediate rsp_ready → grants alternate 0,2,0,2; port 1 is never checked.
- Parallel ports: req0 local and req1 remote valid together → both check pulses in the same cycle on ports 0 and 1; both responses the next cycle.
- Error priority: remote request with rf_sig_err_i=1 and rf_present_remote_i=1 → status SIG_ERR; local request with id_err=1 → ID_ERR.
- Stall: rf_bypass_remote_i high for 5 cycles during a remote ISSUE → no check for 5 cycles, check on the 6th; with the macro defined stall_cnt_o=5.
- Reset mid-RESP with rsp_ready_i held low → after reset all rsp_valid_o=0, FSMs IDLE; the next request to req0 is granted normally with rr_ptr=0.
